// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops complete one edge after accept, MUL takes W+1 edges (shift-add).
// Backpressure: ready low while multiplying; a start with ready low is dropped, never queued.
module alu_seq #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         c_in,
  input  logic [2:0]   Op,
  output logic         ready,
  output logic         done,
  output logic [W-1:0] R,
  output logic [W-1:0] RH,
  output logic         zero,
  output logic         carry,
  output logic         sign,
  output logic         ovf
);
  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  localparam logic [2:0] OP_MUL = 3'b011;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state_q;
  logic [W-1:0]   a_q;
  logic [2*W-1:0] prod_q;
  logic [CW-1:0]  cnt_q;
  logic           ready_q, done_q, zero_q, carry_q, sign_q, ovf_q;
  logic [W-1:0]   r_q, rh_q;

  logic [W:0]     sum_d;
  logic [W-1:0]   r_d;
  logic           carry_d, ovf_d;
  logic [W:0]     hi_sum_d;
  logic [2*W-1:0] prod_d;

  always_comb begin
    sum_d   = '0;
    r_d     = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    case (Op)
      3'b000: r_d = A;
      3'b001: begin
        sum_d   = {1'b0, A} + {1'b0, B} + {{W{1'b0}}, c_in};
        r_d     = sum_d[W-1:0];
        carry_d = sum_d[W];
        ovf_d   = (A[W-1] == B[W-1]) && (sum_d[W-1] != A[W-1]);
      end
      3'b010: begin
        sum_d   = {1'b0, A} + {1'b0, ~B} + {{W{1'b0}}, 1'b1};
        r_d     = sum_d[W-1:0];
        carry_d = sum_d[W];
        ovf_d   = (A[W-1] != B[W-1]) && (sum_d[W-1] != A[W-1]);
      end
      3'b100:  r_d = A & B;
      3'b101:  r_d = A | B;
      3'b110:  r_d = A ^ B;
      3'b111:  r_d = ~A;
      default: r_d = '0;
    endcase
  end

  // Multiplier sits in the low half of prod_q; each step adds A to the high half and shifts right.
  always_comb begin
    hi_sum_d = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, a_q} : '0);
    prod_d   = {hi_sum_d, prod_q[W-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      r_q     <= '0;
      rh_q    <= '0;
      zero_q  <= 1'b1;
      carry_q <= 1'b0;
      sign_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        BUSY: begin
          prod_q <= prod_d;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_q <= DONE;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
            r_q     <= prod_d[W-1:0];
            rh_q    <= prod_d[2*W-1:W];
            zero_q  <= (prod_d == '0);
            carry_q <= (prod_d[2*W-1:W] != '0);
            sign_q  <= prod_d[2*W-1];
            ovf_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          done_q  <= 1'b0;
          if (start) begin
            a_q <= A;
            if (Op == OP_MUL) begin
              state_q <= BUSY;
              ready_q <= 1'b0;
              prod_q  <= {{W{1'b0}}, B};
              cnt_q   <= '0;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
              r_q     <= r_d;
              rh_q    <= '0;
              zero_q  <= (r_d == '0);
              carry_q <= carry_d;
              sign_q  <= r_d[W-1];
              ovf_q   <= ovf_d;
            end
          end
        end
      endcase
    end
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign R     = r_q;
  assign RH    = rh_q;
  assign zero  = zero_q;
  assign carry = carry_q;
  assign sign  = sign_q;
  assign ovf   = ovf_q;
endmodule
